module_rx_shift_reg_spi: RTL and testbench
==========================================

Name: module_rx_shift_reg_spi

Overview:
Serial-to-parallel receive shift register for the SPI master. It is the counterpart of the TX shift register: it captures MISO one bit per sample strobe, counts DATA_WIDTH bits and presents the assembled word with a valid/ack handshake. The SPI controller drives start, abort and the sample strobe; a downstream consumer (register file or FIFO) acknowledges each word.

Parameters:
DATA_WIDTH, 8, bits per frame (≥2)
LSB_FIRST, 0, 0 = first received bit lands in data_o[DATA_WIDTH-1]; 1 = first received bit lands in data_o[0]

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse from the controller; begins a frame
abort_i  in  1  frame abort (CS deasserted early)
sample_en_i  in  1  one-cycle strobe, aligned to the SCLK sampling edge
miso_i  in  1  serial data in, already in the clk_i domain
data_ack_i  in  1  consumer has taken data_o
data_o  out  DATA_WIDTH  last complete received word
valid_o  out  1  data_o holds an unacknowledged word
busy_o  out  1  frame reception in progress
overrun_o  out  1  sticky: a word was overwritten before it was acknowledged

Behaviour:
- Clocking and reset: single clock, one edge. Reset is synchronous and active-high on rst_i.
- Reset values: state IDLE, shift_r=0, bit_cnt=0, data_o=0, valid_o=0, busy_o=0, overrun_o=0. Reset overrides every other input, including mid-frame; a partial word is discarded.
- States: IDLE, RECV. Two states only; completion is handled on the IDLE transition.
- IDLE:
  - sample_en_i is ignored.
  - start_i → RECV next cycle, with shift_r=0, bit_cnt=0, busy_o=1.
- RECV, sample_en_i=1:
  - MSB-first: shift_r <= {shift_r[W-2:0], miso_i}.
  - LSB_FIRST: shift_r <= {miso_i, shift_r[W-1:1]}.
  - bit_cnt increments.
- RECV, sample_en_i=1 and bit_cnt==DATA_WIDTH-1 (last bit):
  - Next cycle: data_o = assembled word including this bit, valid_o=1, busy_o=0, state IDLE.
  - Latency: data_o/valid_o update on the first clk_i edge after the last strobe is registered.
- RECV: start_i is ignored.
- abort_i in RECV:
  - Next cycle: IDLE, busy_o=0, bit_cnt=0.
  - data_o, valid_o and overrun_o are unchanged.
  - abort_i wins over a simultaneous sample_en_i, including on the last bit, so no word is produced.
- Handshake:
  - valid_o clears the cycle after data_ack_i=1.
  - data_ack_i while valid_o=0 has no effect.
  - overrun_o clears together with valid_o on data_ack_i.
- Completion while valid_o=1 and data_ack_i=0: data_o is overwritten, valid_o stays 1, overrun_o set to 1.
- Completion in the same cycle as data_ack_i: the ack applies to the old word, the new word is loaded, valid_o stays 1, no overrun.
- Back-to-back frames: start_i may be asserted in the cycle after completion; the result is 1 idle cycle minimum.
- bit_cnt width: $clog2(DATA_WIDTH); it must never exceed DATA_WIDTH-1.

Decomposition:
- Shared spi_pkg holds:
  - rx_state_t enum {IDLE, RECV}
  - the default SPI_DATA_WIDTH constant, shared with the TX shift register.
- The bit counter is the only natural sub-module: module_bit_counter_spi (clear, enable, terminal-count output at DATA_WIDTH-1). It is reusable by the SPI controller.
- The remainder is one always_ff block plus next-state logic.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, with strobes toggling → all outputs 0. Strobes in IDLE leave data_o=0.
2. MSB-first frame, 8 strobes carrying 1,0,1,0,0,1,0,1 → data_o=8'hA5, valid_o=1 one cycle after the 8th strobe, busy_o=0. Ack → valid_o=0 next cycle.
3. LSB_FIRST=1, 8 strobes carrying 1,1,0,0,0,1,0,1 → data_o=8'hA3. The same bits with LSB_FIRST=0 → 8'hC5.
4. Abort after 3 strobes, with data_o=8'hA5 and valid_o=1 held → state IDLE, busy_o=0, data_o still 8'hA5. A new full frame of 8'h3C then completes correctly.
5. Overrun: complete 8'h11, no ack, then complete 8'h22 → data_o=8'h22, valid_o=1, overrun_o=1. Ack → valid_o=0, overrun_o=0. Repeat with the ack coinciding with the second completion → overrun_o stays 0.
6. Edge collisions and mid-frame reset:
   - abort_i together with the 8th strobe → no valid.
   - start_i during RECV → ignored, frame completes normally.
   - rst_i after 5 strobes → all outputs 0; the next frame 8'hF0 decodes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions used by the TX/RX shift registers and
//                the SPI controller: default frame width and the receive-side
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default frame width shared by the TX and RX shift registers.
  localparam int SPI_DATA_WIDTH = 8;

  // Receive shifter states. Completion needs no state of its own: the final
  // strobe loads the output word on the same edge that returns to IDLE.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/module_bit_counter_spi.sv
`default_nettype none
// ============================================================================
//  Module      : module_bit_counter_spi
//  Description : Frame bit counter. Counts enable pulses from 0 up to
//                DATA_WIDTH-1 and flags the terminal count. Enabling at the
//                terminal count wraps to 0, so the count never exceeds
//                DATA_WIDTH-1.
//  Ports       : clk      - system clock
//                rst      - synchronous reset, active-high
//                clear    - return the count to 0 (wins over enable)
//                enable   - advance the count by one
//                terminal - count is at DATA_WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module module_bit_counter_spi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST_CNT);

endmodule : module_bit_counter_spi
`default_nettype wire

// File: rtl/module_rx_shift_reg_spi.sv
`default_nettype none
// ============================================================================
//  Module      : module_rx_shift_reg_spi
//  Description : SPI master receive shift register. Captures MISO on each
//                sample strobe, assembles DATA_WIDTH bits and presents the
//                word with a valid/ack handshake and a sticky overrun flag.
//  Ports       : clk_i       - system clock
//                rst_i       - synchronous reset, active-high
//                start_i     - one-cycle pulse, begins a frame
//                abort_i     - abandon the current frame
//                sample_en_i - one-cycle strobe on the SCLK sampling edge
//                miso_i      - serial data in (clk_i domain)
//                data_ack_i  - consumer has taken data_o
//                data_o      - last complete received word
//                valid_o     - data_o holds an unacknowledged word
//                busy_o      - frame reception in progress
//                overrun_o   - a word was overwritten before being acked
//  Revision    : 1.0 - initial release
// ============================================================================
module module_rx_shift_reg_spi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  sample_en_i,
  input  logic                  miso_i,
  input  logic                  data_ack_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  rx_state_t             state, state_next;
  logic [DATA_WIDTH-1:0] shift_r, shift_next;
  logic                  last_bit;
  logic                  cnt_clear;
  logic                  shift_en;
  logic                  shift_clear;
  logic                  load_word;

  module_bit_counter_spi #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (cnt_clear),
    .enable   (shift_en),
    .terminal (last_bit)
  );

  // Shift direction decides where the first received bit ends up.
  if (LSB_FIRST) begin : g_lsb_first
    assign shift_next = {miso_i, shift_r[DATA_WIDTH-1:1]};
  end else begin : g_msb_first
    assign shift_next = {shift_r[DATA_WIDTH-2:0], miso_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_clear   = 1'b0;
    shift_clear = 1'b0;
    shift_en    = 1'b0;
    load_word   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next  = RECV;
          cnt_clear   = 1'b1;
          shift_clear = 1'b1;
        end
      end
      RECV: begin
        // Abort outranks the strobe, even on the last bit.
        if (abort_i) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (sample_en_i) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_next = IDLE;
            load_word  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_r   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (shift_clear) begin
        shift_r <= '0;
      end else if (shift_en) begin
        shift_r <= shift_next;
      end

      if (load_word) begin
        // The word includes the bit arriving with this strobe. A coincident
        // ack retires the old word, so only an unacked word counts as lost.
        data_o    <= shift_next;
        valid_o   <= 1'b1;
        overrun_o <= valid_o & ~data_ack_i;
      end else if (data_ack_i) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state == RECV);

endmodule : module_rx_shift_reg_spi
`default_nettype wire

// File: tb/tb_module_rx_shift_reg_spi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_module_rx_shift_reg_spi
//  Description : Self-checking bench for module_rx_shift_reg_spi. An MSB-first
//                and an LSB-first instance share one stimulus stream; expected
//                words and handshake flags come from a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_module_rx_shift_reg_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sample_en = 1'b0;
  logic       miso = 1'b0;
  logic       data_ack = 1'b0;

  logic [7:0] msb_data, lsb_data;
  logic       msb_valid, lsb_valid;
  logic       msb_busy, lsb_busy;
  logic       msb_over, lsb_over;

  int total = 0;
  int bad   = 0;

  // Frame-level model: word as seen MSB-first, plus handshake flags.
  logic [7:0] exp_word  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_over  = 1'b0;
  logic       exp_busy  = 1'b0;

  always #5 clk = ~clk;

  module_rx_shift_reg_spi #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .sample_en_i(sample_en), .miso_i(miso), .data_ack_i(data_ack),
    .data_o(msb_data), .valid_o(msb_valid), .busy_o(msb_busy),
    .overrun_o(msb_over)
  );

  module_rx_shift_reg_spi #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .sample_en_i(sample_en), .miso_i(miso), .data_ack_i(data_ack),
    .data_o(lsb_data), .valid_o(lsb_valid), .busy_o(lsb_busy),
    .overrun_o(lsb_over)
  );

  // Arrival order reversed: first bit received becomes bit 0.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".msb_data"},  msb_data,         exp_word);
    check({tag, ".lsb_data"},  lsb_data,         rev8(exp_word));
    check({tag, ".msb_valid"}, {7'd0, msb_valid}, {7'd0, exp_valid});
    check({tag, ".lsb_valid"}, {7'd0, lsb_valid}, {7'd0, exp_valid});
    check({tag, ".busy"},      {6'd0, msb_busy, lsb_busy}, {6'd0, exp_busy, exp_busy});
    check({tag, ".overrun"},   {6'd0, msb_over, lsb_over}, {6'd0, exp_over, exp_over});
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    exp_valid = 1'b0;
    exp_over  = 1'b0;
  endtask

  // Runs one frame. f holds the bits in arrival order from f[7] down to f[0].
  // abort_at: strobe index at which the frame is aborted (-1 = never);
  // abort_with: abort rides on that strobe rather than preceding it alone.
  task automatic run_frame(input logic [7:0] f, input int abort_at, input bit abort_with,
                           input bit ack_last, input bit gaps, input bit start_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_busy = 1'b1;
    check("frame.busy_after_start", {6'd0, msb_busy, lsb_busy}, 8'h03);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int g = $urandom_range(2);
        for (int k = 0; k < g; k++) tick();
      end
      if (i == abort_at && !abort_with) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_busy = 1'b0;
        return;
      end
      sample_en = 1'b1;
      miso      = f[7-i];
      abort     = (i == abort_at);
      start     = start_mid && (i == 3);
      data_ack  = ack_last && (i == 7);
      tick();
      sample_en = 1'b0;
      abort     = 1'b0;
      start     = 1'b0;
      data_ack  = 1'b0;
      if (i == abort_at) begin
        exp_busy = 1'b0;
        return;
      end
    end
    exp_busy = 1'b0;
    if (ack_last)       exp_over = 1'b0;
    else if (exp_valid) exp_over = 1'b1;
    exp_valid = 1'b1;
    exp_word  = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b1;
    miso = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    rst = 1'b0;
    miso = 1'b0;
    exp_word = 8'h00; exp_valid = 1'b0; exp_over = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin
    // 1. Reset with strobes toggling, then strobes in IDLE.
    do_reset();
    check_all("reset");
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1;
      miso = 1'b1;
      tick();
      sample_en = 1'b0;
    end
    check_all("idle_strobes");

    // 2. MSB-first frame 1,0,1,0,0,1,0,1.
    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("frame_a5");
    ack_pulse();
    check_all("ack_a5");

    // 3. Bits 1,1,0,0,0,1,0,1: 8'hC5 MSB-first, 8'hA3 LSB-first.
    run_frame(8'hC5, -1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lsb_first_a3", lsb_data, 8'hA3);
    check("msb_first_c5", msb_data, 8'hC5);
    ack_pulse();

    // 4. Abort after 3 strobes with A5 held valid, then a clean 3C frame.
    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("abort_mid");
    run_frame(8'h3C, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("after_abort_3c");
    ack_pulse();
    check_all("ack_3c");

    // 5. Overrun, then completion coinciding with ack.
    run_frame(8'h11, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h22, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("overrun_set");
    ack_pulse();
    check_all("overrun_cleared");
    run_frame(8'h11, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h22, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("ack_with_completion");
    ack_pulse();

    // 6. Edge collisions and mid-frame reset.
    run_frame(8'h5A, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("abort_on_last");
    run_frame(8'h96, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_all("start_in_recv");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1;
      miso = 1'b1;
      tick();
      sample_en = 1'b0;
    end
    do_reset();
    check_all("reset_mid_frame");
    run_frame(8'hF0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("frame_f0");

    // Randomized frames with random acks, gaps, and aborts.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] f;
      int         ab;
      bit         abw, ackl;
      f    = 8'($urandom);
      ab   = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
      abw  = 1'($urandom_range(1));
      ackl = (ab < 0) ? 1'($urandom_range(1)) : 1'b0;
      if ($urandom_range(1) == 1) ack_pulse();
      run_frame(f, ab, abw, ackl, 1'($urandom_range(1)), 1'($urandom_range(1)));
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_module_rx_shift_reg_spi
`default_nettype wire
